aysm_nibble_reader: RTL and testbench

AYSM_NIBBLE_READER -- requirements
Module: aysm_nibble_reader

---
 rtl/aysm_nibble_reader.sv | 178 +++++++++++++++++
 tb/tb_aysm_nibble_reader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/aysm_nibble_reader.sv
// Streams a burst of narrow lanes out of a wide-word RAM port. Each word is
// fetched once and its lanes leave through a valid/ready output handshake.

module aysm_nibble_reader_chk #(
  parameter int WIDTHB = 4
) (
  input logic              clkA,
  input logic              rst,
  input logic              weA,
  input logic              dout_valid,
  input logic              dout_ready,
  input logic              busy,
  input logic              done,
  input logic [WIDTHB-1:0] dout
);
  a_we_low: assert property (@(posedge clkA) disable iff (rst) !weA);
  a_hold: assert property (@(posedge clkA) disable iff (rst)
    (dout_valid && !dout_ready) |=> (dout_valid && $stable(dout)));
  a_busy: assert property (@(posedge clkA) disable iff (rst) (dout_valid || done) |-> busy);
  a_done_pulse: assert property (@(posedge clkA) disable iff (rst) done |=> !done);
endmodule

module aysm_nibble_reader #(
  parameter int WIDTHA     = 16,
  parameter int WIDTHB     = 4,
  parameter int ADDRWIDTHA = 8,
  parameter int ADDRWIDTHB = 10,
  parameter int RATIO      = WIDTHA / WIDTHB
) (
  input  logic                  clkA,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDRWIDTHB-1:0] base_addr,
  input  logic [ADDRWIDTHB:0]   len,
  output logic [ADDRWIDTHA-1:0] addrA,
  output logic                  weA,
  input  logic [WIDTHA-1:0]     doA,
  output logic [WIDTHB-1:0]     dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  done
);
  localparam int LANEW = $clog2(RATIO);
  localparam logic [LANEW-1:0]      LANE_ONE  = {{(LANEW-1){1'b0}}, 1'b1};
  localparam logic [LANEW-1:0]      LANE_LAST = {LANEW{1'b1}};
  localparam logic [ADDRWIDTHB-1:0] PTR_ONE   = {{(ADDRWIDTHB-1){1'b0}}, 1'b1};
  localparam logic [ADDRWIDTHB:0]   REM_ONE   = {{ADDRWIDTHB{1'b0}}, 1'b1};
  localparam logic [ADDRWIDTHB:0]   REM_ZERO  = {(ADDRWIDTHB+1){1'b0}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WAIT   = 3'd2,
    STREAM = 3'd3,
    FIN    = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDRWIDTHB-1:0] r_nib_ptr;
  logic [ADDRWIDTHB:0]   r_remaining;
  logic [WIDTHA-1:0]     r_word_buf;
  logic [ADDRWIDTHA-1:0] r_addr;
  logic [WIDTHB-1:0]     r_dout;
  logic                  r_dout_valid;
  logic                  r_busy;
  logic                  r_done;

  logic [LANEW-1:0] w_lane;
  logic [LANEW-1:0] w_lane_nxt;
  logic             w_xfer;
  logic             w_last;
  logic             w_word_end;

  function automatic logic [WIDTHB-1:0] pick_lane(input logic [WIDTHA-1:0] word,
                                                  input logic [LANEW-1:0]  lane);
    logic [WIDTHA-1:0] sh;
    sh = word >> (WIDTHB * int'(lane));
    return sh[WIDTHB-1:0];
  endfunction

  assign w_lane     = r_nib_ptr[LANEW-1:0];
  assign w_lane_nxt = w_lane + LANE_ONE;
  assign w_xfer     = r_dout_valid & dout_ready;
  assign w_last     = (r_remaining == REM_ONE);
  assign w_word_end = (w_lane == LANE_LAST);

  // The next lane is preloaded into dout on each transfer so dout never depends on ready.
  always_ff @(posedge clkA or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_nib_ptr    <= {ADDRWIDTHB{1'b0}};
      r_remaining  <= REM_ZERO;
      r_word_buf   <= {WIDTHA{1'b0}};
      r_addr       <= {ADDRWIDTHA{1'b0}};
      r_dout       <= {WIDTHB{1'b0}};
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            if (len != REM_ZERO) begin
              r_nib_ptr   <= base_addr;
              r_remaining <= len;
              r_state     <= ADDR;
            end else begin
              r_done  <= 1'b1;
              r_state <= FIN;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        ADDR: begin
          r_addr  <= ADDRWIDTHA'(r_nib_ptr >> LANEW);
          r_state <= WAIT;
        end
        WAIT: begin
          r_word_buf   <= doA;
          r_dout       <= pick_lane(doA, w_lane);
          r_dout_valid <= 1'b1;
          r_state      <= STREAM;
        end
        STREAM: begin
          if (w_xfer) begin
            r_nib_ptr   <= r_nib_ptr + PTR_ONE;
            r_remaining <= r_remaining - REM_ONE;
            if (w_last) begin
              r_dout_valid <= 1'b0;
              r_done       <= 1'b1;
              r_state      <= FIN;
            end else if (w_word_end) begin
              r_dout_valid <= 1'b0;
              r_state      <= ADDR;
            end else begin
              r_dout <= pick_lane(r_word_buf, w_lane_nxt);
            end
          end else begin
            r_state <= STREAM;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_dout_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign addrA      = r_addr;
  assign weA        = 1'b0;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign done       = r_done;

  aysm_nibble_reader_chk #(.WIDTHB(WIDTHB)) u_chk (
    .clkA       (clkA),
    .rst        (rst),
    .weA        (weA),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done),
    .dout       (dout)
  );
endmodule

// File: tb/tb_aysm_nibble_reader.sv
// Bench for aysm_nibble_reader: directed bursts plus randomized bursts, every
// transfer compared against nibbles computed from a 256x16 RAM image.
module tb_aysm_nibble_reader;
  logic        clkA = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] len;
  logic [7:0]  addrA;
  logic        weA;
  logic [15:0] doA;
  logic [3:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;
  logic        done;

  logic [15:0] mem [256];
  int          n_tot = 0;
  int          n_bad = 0;
  logic [3:0]  got_q [$];
  logic [7:0]  adr_q [$];

  always #5 clkA = ~clkA;

  // RAM read through the DUT's registered word address
  assign doA = mem[addrA];

  aysm_nibble_reader dut (
    .clkA       (clkA),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .addrA      (addrA),
    .weA        (weA),
    .doA        (doA),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clkA);
    #1;
  endtask

  function automatic logic [3:0] exp_nib(input int p);
    logic [7:0]  wa;
    logic [15:0] w;
    wa = 8'(p >> 2);
    w  = mem[wa];
    return 4'(w >> (4 * (p & 3)));
  endfunction

  // One burst: each transfer checked against the RAM image; abort_at>0 resets after that many.
  task automatic run_burst(input logic [9:0] b, input int n, input int mode,
                           input int abort_at, input bit spam);
    int k, low, cyc, stall, we_bad, done_bad, busy_bad, p;
    logic held, r;
    logic [3:0] held_d;
    logic [7:0] a0;
    got_q.delete();
    adr_q.delete();
    k = 0; low = 0; cyc = 0; stall = 0; we_bad = 0; done_bad = 0; busy_bad = 0;
    held = 1'b0; held_d = 4'h0;
    a0 = addrA;
    base_addr = b; len = 11'(n); start = 1'b1; dout_ready = 1'b1;
    tick();
    start = 1'b0;
    if (n == 0) begin
      chk("z_busy", busy, 1); chk("z_done", done, 1);
      chk("z_valid", dout_valid, 0); chk("z_addr", addrA, a0);
      tick();
      chk("z_done_off", done, 0); chk("z_idle", busy, 0); chk("z_addr2", addrA, a0);
      return;
    end
    while (k < n && cyc < 40 * n + 50) begin
      if (weA) we_bad++;
      if (done) done_bad++;
      if (!busy) busy_bad++;
      if (held) begin
        chk("hold_valid", dout_valid, 1);
        chk("hold_dout", dout, held_d);
      end
      if (!dout_valid) low++;
      if (mode == 0) r = 1'b1;
      else if (mode == 2) begin
        if (k == 1 && dout_valid && stall < 5) begin r = 1'b0; stall++; end
        else r = 1'b1;
      end else r = ($urandom_range(0, 3) != 0);
      dout_ready = r;
      start = spam && ($urandom_range(0, 2) == 0);
      base_addr = 10'($urandom);
      len = 11'($urandom_range(0, 20));
      held = dout_valid && !r;
      held_d = dout;
      if (dout_valid && r) begin
        p = (int'(b) + k) % 1024;
        chk("nibble", dout, exp_nib(p));
        chk("addrA", addrA, p >> 2);
        chk("bubble", low, (k == 0 || p % 4 == 0) ? 2 : 0);
        got_q.push_back(dout);
        adr_q.push_back(addrA);
        k++;
        low = 0;
        if (k == abort_at) begin
          start = 1'b0;
          tick();
          #3 rst = 1'b1;
          #1;
          chk("rst_valid", dout_valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
          chk("rst_dout", dout, 0); chk("rst_addr", addrA, 0);
          @(posedge clkA);
          #1 rst = 1'b0;
          return;
        end
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    dout_ready = 1'b1;
    if (k != n) chk("timeout_xfers", k, n);
    chk("fin_done", done, 1); chk("fin_valid", dout_valid, 0); chk("fin_busy", busy, 1);
    tick();
    chk("done_pulse", done, 0); chk("back_idle", busy, 0);
    chk("cnt_we", we_bad, 0); chk("cnt_early_done", done_bad, 0); chk("cnt_busy_drop", busy_bad, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = 10'h000; len = 11'h000; dout_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    repeat (2) @(posedge clkA);
    #1;
    chk("reset_addr", addrA, 0); chk("reset_dout", dout, 0); chk("reset_valid", dout_valid, 0);
    chk("reset_busy", busy, 0); chk("reset_done", done, 0); chk("reset_we", weA, 0);
    rst = 1'b0;

    mem[8'h10] = 16'hABCD;
    run_burst(10'h040, 4, 0, 0, 1'b0);
    chk("s1_count", got_q.size(), 4);
    chk("s1_n0", got_q[0], 4'hD); chk("s1_n1", got_q[1], 4'hC);
    chk("s1_n2", got_q[2], 4'hB); chk("s1_n3", got_q[3], 4'hA);
    chk("s1_addr", adr_q[0], 8'h10);

    mem[8'h11] = 16'h1234;
    run_burst(10'h042, 3, 0, 0, 1'b0);
    chk("s2_n0", got_q[0], 4'hB); chk("s2_n1", got_q[1], 4'hA); chk("s2_n2", got_q[2], 4'h4);
    chk("s2_addr0", adr_q[0], 8'h10); chk("s2_addr1", adr_q[2], 8'h11);

    mem[8'hFF] = 16'h9876;
    mem[8'h00] = 16'h5432;
    run_burst(10'h3FE, 4, 0, 0, 1'b0);
    chk("s3_n0", got_q[0], 4'h8); chk("s3_n1", got_q[1], 4'h9);
    chk("s3_n2", got_q[2], 4'h2); chk("s3_n3", got_q[3], 4'h3);
    chk("s3_addr0", adr_q[0], 8'hFF); chk("s3_addr1", adr_q[2], 8'h00);

    run_burst(10'h040, 4, 2, 0, 1'b0);
    chk("s4_count", got_q.size(), 4);
    chk("s4_n1", got_q[1], 4'hC); chk("s4_n3", got_q[3], 4'hA);

    run_burst(10'h155, 0, 0, 0, 1'b0);
    run_burst(10'h040, 4, 1, 0, 1'b1);
    chk("s5_count", got_q.size(), 4);
    run_burst(10'h043, 9, 1, 0, 1'b1);

    run_burst(10'h040, 8, 0, 2, 1'b0);
    chk("s6_count", got_q.size(), 2);
    run_burst(10'h042, 3, 0, 0, 1'b0);
    chk("s6_n0", got_q[0], 4'hB); chk("s6_n1", got_q[1], 4'hA); chk("s6_n2", got_q[2], 4'h4);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      run_burst(10'($urandom), int'($urandom_range(0, (t % 4 == 0) ? 70 : 12)), 1, 0,
                ($urandom_range(0, 1) == 1));
    end
    run_burst(10'($urandom), 1024, 1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
